// File: rtl/spi_dac_pkg.sv
// Shared types and width helpers for the multi-channel SPI DAC driver.
package spi_dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } spi_dac_state_t;

    localparam logic SPI_DAC_SCLK_IDLE = 1'b1;

    // Counter width that never collapses to zero bits for n <= 1.
    function automatic int spi_dac_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_en.sv
// Tick generator: a one-cycle tick every CLK_DIV sys_clk cycles, restartable with clr.
module spi_clk_en
    import spi_dac_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = spi_dac_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_dac_multi.sv
// Multi-channel SPI DAC driver: shared sclk/cs_n, one MSB-first mosi line per channel.
// Define SPI_DAC_CONT_EN for continuous refresh of the last captured samples.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SHIFT | cs_n low, frame shifting out on all channels
// GAP   | cs_n high for the inter-frame gap
module spi_dac_multi
    import spi_dac_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 12,
    parameter int FRAME_W  = 16,
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 2
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CHANNELS*DATA_W-1:0]   din,
    output logic                         ready,
    output logic                         done,
    output logic                         sclk,
    output logic                         cs_n,
    output logic [CHANNELS-1:0]          mosi
);

    localparam int BIT_W   = spi_dac_cnt_w(FRAME_W + 1);
    localparam int GAP_CYC = 2 * CS_GAP * CLK_DIV;
    localparam int GAP_W   = spi_dac_cnt_w(GAP_CYC);

    spi_dac_state_t                   state;
    logic [CHANNELS-1:0][FRAME_W-1:0] sr;
    logic [CHANNELS-1:0][FRAME_W-1:0] sr_shl;
    logic [CHANNELS-1:0][FRAME_W-1:0] load_word;
    logic [BIT_W-1:0]                 bit_cnt;
    logic [GAP_W-1:0]                 gap_cnt;
    logic [CHANNELS*DATA_W-1:0]       src;
    logic                             tick;
    logic                             accept;
    logic                             load;

    assign accept = ready && start;

`ifdef SPI_DAC_CONT_EN
    logic [CHANNELS*DATA_W-1:0] hold;

    // The last gap cycle always restarts a frame, with new samples only if start was taken.
    assign load = accept || (state == GAP && gap_cnt == '0);
    assign src  = accept ? din : hold;
`else
    assign load = accept;
    assign src  = din;
`endif

    always_comb begin
        sr_shl    = '0;
        load_word = '0;
        mosi      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sr_shl[k]    = sr[k] << 1;
            load_word[k] = FRAME_W'(src[k*DATA_W +: DATA_W]);
            mosi[k]      = sr[k][FRAME_W-1];
        end
    end

    spi_clk_en #(.CLK_DIV(CLK_DIV)) u_clk_en (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (load),
        .tick    (tick)
    );

    // The final rising tick shifts the last bit out, so sr is all zero (mosi=0) outside SHIFT.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b0;
            done    <= 1'b0;
            sclk    <= SPI_DAC_SCLK_IDLE;
            cs_n    <= 1'b1;
            sr      <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
`ifdef SPI_DAC_CONT_EN
            hold    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= SHIFT;
                ready   <= 1'b0;
                cs_n    <= 1'b0;
                sclk    <= SPI_DAC_SCLK_IDLE;
                sr      <= load_word;
                bit_cnt <= BIT_W'(FRAME_W);
`ifdef SPI_DAC_CONT_EN
                if (accept) hold <= din;
`endif
            end else begin
                case (state)
                    IDLE: ready <= 1'b1;
                    SHIFT: begin
                        if (tick) begin
                            if (sclk) begin
                                sclk    <= 1'b0;
                                bit_cnt <= bit_cnt - BIT_W'(1);
                            end else begin
                                sclk <= 1'b1;
                                sr   <= sr_shl;
                                if (bit_cnt == '0) begin
                                    cs_n    <= 1'b1;
                                    done    <= 1'b1;
                                    state   <= GAP;
                                    gap_cnt <= GAP_W'(GAP_CYC - 1);
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == '0) begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
`ifdef SPI_DAC_CONT_EN
                            if (gap_cnt == GAP_W'(1)) ready <= 1'b1;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
